// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and parameter checks for the hazard control unit
package hazard_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_t;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  localparam int REG_ZERO = 0;

  // MUL/DIV must occupy EX for at least the issue cycle plus the release cycle
  function automatic bit mdu_latency_ok(input int lat);
    return lat >= 2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller for load-use, MUL/DIV and taken branches
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int MDU_LATENCY = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] D_Rs1,
  input  logic [DATA_WIDTH-1:0] D_Rs2,
  input  logic                  D_UsesRs1,
  input  logic                  D_UsesRs2,
  input  logic [DATA_WIDTH-1:0] E_Rd,
  input  logic                  E_MemRead,
  input  logic                  E_MduStart,
  input  logic                  E_BranchTaken,
  output logic                  F_Stall,
  output logic                  D_Stall,
  output logic                  D_Flush,
  output logic                  E_Stall,
  output logic                  E_Flush,
  output logic                  M_Flush,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  StallCycles
);

  localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 2);

  if (!mdu_latency_ok(MDU_LATENCY)) begin : g_bad_latency
    $error("hazard_control_unit: MDU_LATENCY must be at least 2");
  end

  hz_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          load_use;

  // a load in EX whose destination is read by the ID instruction cannot be bypassed in time
  always_comb begin
    load_use = E_MemRead && (E_Rd != DATA_WIDTH'(REG_ZERO)) &&
               ((D_UsesRs1 && (D_Rs1 == E_Rd)) || (D_UsesRs2 && (D_Rs2 == E_Rd)));
  end

  // state and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // next-state and control outputs; everything is quiet while reset is held
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    F_Stall    = 1'b0;
    D_Stall    = 1'b0;
    D_Flush    = 1'b0;
    E_Stall    = 1'b0;
    E_Flush    = 1'b0;
    M_Flush    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (E_BranchTaken) begin
            // redirect wins: the wrong-path instructions in IF/ID and ID/EX are squashed
            D_Flush = 1'b1;
            E_Flush = 1'b1;
          end else if (E_MduStart) begin
            F_Stall    = 1'b1;
            D_Stall    = 1'b1;
            E_Stall    = 1'b1;
            M_Flush    = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = MDU_WAIT;
          end else if (load_use) begin
            F_Stall = 1'b1;
            D_Stall = 1'b1;
            E_Flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          // E_MduStart is still high from the same held instruction, so it is not looked at
          if (cnt != '0) begin
            F_Stall  = 1'b1;
            D_Stall  = 1'b1;
            E_Stall  = 1'b1;
            M_Flush  = 1'b1;
            cnt_next = cnt - 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign Busy = (state == MDU_WAIT);

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(F_Stall),
    .q  (StallCycles)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_BR    = 6'b001010;
  localparam logic [5:0] C_STALL = 6'b110101;

  typedef struct {
    logic       mem_read;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mdu;
    logic       br;
    logic [5:0] exp_ctrl;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic       d_u1, d_u2, e_mem, e_mdu, e_br;

  logic f4, ds4, df4, es4, ef4, mf4, busy4;
  logic f2, ds2, df2, es2, ef2, mf2, busy2;
  logic f32, ds32, df32, es32, ef32, mf32, busy32;
  logic [15:0] cyc4, cyc2;
  logic [3:0]  cyc32;
  logic [5:0]  c4, c2, c32;

  assign c4  = {f4, ds4, df4, es4, ef4, mf4};
  assign c2  = {f2, ds2, df2, es2, ef2, mf2};
  assign c32 = {f32, ds32, df32, es32, ef32, mf32};

  int passed = 0;
  int total  = 0;
  vec_t vecs[9];

  hazard_control_unit #(.DATA_WIDTH(5), .MDU_LATENCY(4), .CNT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .D_Rs1(d_rs1), .D_Rs2(d_rs2), .D_UsesRs1(d_u1), .D_UsesRs2(d_u2),
    .E_Rd(e_rd), .E_MemRead(e_mem), .E_MduStart(e_mdu), .E_BranchTaken(e_br),
    .F_Stall(f4), .D_Stall(ds4), .D_Flush(df4), .E_Stall(es4), .E_Flush(ef4), .M_Flush(mf4),
    .Busy(busy4), .StallCycles(cyc4)
  );

  hazard_control_unit #(.DATA_WIDTH(5), .MDU_LATENCY(2), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .D_Rs1(d_rs1), .D_Rs2(d_rs2), .D_UsesRs1(d_u1), .D_UsesRs2(d_u2),
    .E_Rd(e_rd), .E_MemRead(e_mem), .E_MduStart(e_mdu), .E_BranchTaken(e_br),
    .F_Stall(f2), .D_Stall(ds2), .D_Flush(df2), .E_Stall(es2), .E_Flush(ef2), .M_Flush(mf2),
    .Busy(busy2), .StallCycles(cyc2)
  );

  hazard_control_unit #(.DATA_WIDTH(5), .MDU_LATENCY(32), .CNT_WIDTH(4)) dut32 (
    .clk(clk), .rst(rst), .D_Rs1(d_rs1), .D_Rs2(d_rs2), .D_UsesRs1(d_u1), .D_UsesRs2(d_u2),
    .E_Rd(e_rd), .E_MemRead(e_mem), .E_MduStart(e_mdu), .E_BranchTaken(e_br),
    .F_Stall(f32), .D_Stall(ds32), .D_Flush(df32), .E_Stall(es32), .E_Flush(ef32), .M_Flush(mf32),
    .Busy(busy32), .StallCycles(cyc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; e_rd = '0;
    d_u1 = 1'b0; d_u2 = 1'b0; e_mem = 1'b0; e_mdu = 1'b0; e_br = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, C_LU,   "lu_rs1"};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, C_NONE, "lu_rd_zero"};
    vecs[2] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "lu_no_use_rs1"};
    vecs[3] = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b0, 1'b1, 1'b0, 1'b0, C_LU,   "lu_rs2"};
    vecs[4] = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, C_NONE, "lu_no_use_rs2"};
    vecs[5] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, C_NONE, "no_load"};
    vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, C_BR,   "branch"};
    vecs[7] = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, C_BR,   "branch_prio"};
    vecs[8] = '{1'b1, 5'd31, 5'd30, 5'd29, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE, "lu_mismatch"};

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    e_br = 1'b1; e_mdu = 1'b1;
    #1;
    chk("rst_ctrl_forced_0", {26'd0, c4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("reset_busy", {31'd0, busy4}, 32'd0);
    chk("reset_count", {16'd0, cyc4}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e_mem = vecs[i].mem_read; e_rd = vecs[i].rd;
      d_rs1 = vecs[i].rs1; d_rs2 = vecs[i].rs2;
      d_u1 = vecs[i].u1; d_u2 = vecs[i].u2;
      e_mdu = vecs[i].mdu; e_br = vecs[i].br;
      #1;
      chk({vecs[i].name, "_l4"},  {26'd0, c4},  {26'd0, vecs[i].exp_ctrl});
      chk({vecs[i].name, "_l2"},  {26'd0, c2},  {26'd0, vecs[i].exp_ctrl});
      chk({vecs[i].name, "_l32"}, {26'd0, c32}, {26'd0, vecs[i].exp_ctrl});
      chk({vecs[i].name, "_busy"}, {31'd0, busy4}, 32'd0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("branch_kept_idle", {31'd0, busy4}, 32'd0);
    chk("lu_stall_count", {16'd0, cyc4}, 32'd2);

    // MUL/DIV occupancy: latency 4 and latency 2 (with back-to-back restart)
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      e_mdu = (k < 4);
      #1;
      chk($sformatf("l4_ctrl_c%0d", k), {26'd0, c4}, {26'd0, (k < 3) ? C_STALL : C_NONE});
      chk($sformatf("l4_busy_c%0d", k), {31'd0, busy4}, {31'd0, (k >= 1 && k <= 3)});
      chk($sformatf("l2_ctrl_c%0d", k), {26'd0, c2}, {26'd0, (k == 0 || k == 2) ? C_STALL : C_NONE});
      chk($sformatf("l2_busy_c%0d", k), {31'd0, busy2}, {31'd0, (k == 1 || k == 3)});
    end
    chk("l4_stall_count", {16'd0, cyc4}, 32'd3);
    chk("l2_stall_count", {16'd0, cyc2}, 32'd2);

    // reset in the middle of a 32-cycle wait
    do_reset();
    e_mdu = 1'b1;
    #1;
    chk("l32_start", {26'd0, c32}, {26'd0, C_STALL});
    @(negedge clk);
    #1;
    chk("l32_busy_c1", {31'd0, busy32}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("l32_rst_ctrl", {26'd0, c32}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    e_mdu = 1'b0;
    #1;
    chk("l32_busy_after_rst", {31'd0, busy32}, 32'd0);
    chk("l32_count_after_rst", {28'd0, cyc32}, 32'd0);
    chk("l32_ctrl_after_rst", {26'd0, c32}, 32'd0);

    // fresh 32-cycle op; the 4-bit counter must stick at 15
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      e_mdu = (k < 32);
      #1;
      if (k == 0) begin
        chk("l32_restart_ctrl", {26'd0, c32}, {26'd0, C_STALL});
        chk("l32_restart_busy", {31'd0, busy32}, 32'd0);
      end
      if (k == 20) chk("l32_sat_mid", {28'd0, cyc32}, 32'd15);
      if (k == 30) chk("l32_last_stall", {26'd0, c32}, {26'd0, C_STALL});
      if (k == 31) begin
        chk("l32_release_ctrl", {26'd0, c32}, 32'd0);
        chk("l32_release_busy", {31'd0, busy32}, 32'd1);
      end
      if (k == 32) begin
        chk("l32_done_busy", {31'd0, busy32}, 32'd0);
        chk("l32_sat_end", {28'd0, cyc32}, 32'd15);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline stall/flush controller for the 5-stage RISC-V core. It is the complement of operand forwarding: it resolves the hazards that bypassing cannot resolve. These are load-use dependencies, multi-cycle MUL/DIV occupancy of EX, and taken-branch redirection. It drives hold/bubble controls of the F, D, E and M pipeline registers and keeps a saturating stall-cycle performance counter.

Parameters:
DATA_WIDTH, 5, register index width
MDU_LATENCY, 32, total cycles a MUL/DIV instruction occupies EX; legal range >= 2
CNT_WIDTH, 16, width of stall performance counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous reset, active-high
D_Rs1  input  DATA_WIDTH  rs1 index of instruction in ID
D_Rs2  input  DATA_WIDTH  rs2 index of instruction in ID
D_UsesRs1  input  1  ID instruction reads rs1
D_UsesRs2  input  1  ID instruction reads rs2
E_Rd  input  DATA_WIDTH  rd index of instruction in EX
E_MemRead  input  1  EX instruction is a load
E_MduStart  input  1  EX instruction is MUL/DIV (level, held while it sits in EX)
E_BranchTaken  input  1  EX resolved a taken branch/jump
F_Stall  output  1  hold PC
D_Stall  output  1  hold IF/ID register
D_Flush  output  1  zero IF/ID register (bubble)
E_Stall  output  1  hold ID/EX register
E_Flush  output  1  zero ID/EX register (bubble)
M_Flush  output  1  zero EX/MEM register (bubble)
Busy  output  1  FSM in MDU_WAIT
StallCycles  output  CNT_WIDTH  saturating count of cycles with F_Stall=1

Behaviour:
- The only decided interface rule is one clock (clk) and a synchronous, active-high reset (rst).
- FSM states: IDLE, MDU_WAIT. Down-counter cnt, width $clog2(MDU_LATENCY).
- rst=1 at a clock edge sets state to IDLE, cnt to 0 and StallCycles to 0.
  - While rst is high, every control output is forced to 0.
  - Reset during MDU_WAIT aborts the wait immediately.
- Control outputs are combinational from state, cnt and inputs. They are valid in the same cycle.
- IDLE, evaluated in priority order:
  1. E_BranchTaken=1: D_Flush=1, E_Flush=1, no stall. A load-use or MDU condition in the same cycle is ignored for stalling.
  2. E_MduStart=1: F_Stall=D_Stall=E_Stall=1, M_Flush=1. Load cnt<=MDU_LATENCY-2. Next state MDU_WAIT.
  3. Load-use: E_MemRead and E_Rd!=0 and ((D_UsesRs1 and D_Rs1==E_Rd) or (D_UsesRs2 and D_Rs2==E_Rd)). Assert F_Stall=D_Stall=1, E_Flush=1 for exactly that cycle. Stay in IDLE.
  4. Otherwise all controls are 0.
- MDU_WAIT:
  - E_MduStart is ignored, because the same instruction is still held in EX.
  - cnt!=0: F_Stall=D_Stall=E_Stall=1, M_Flush=1, cnt<=cnt-1.
  - cnt==0: all controls are 0 and next state is IDLE. This is the final EX cycle; the instruction advances.
  - Net effect: MDU_LATENCY-1 stall cycles and MDU_LATENCY cycles of EX occupancy.
- Busy=1 exactly when state==MDU_WAIT.
- StallCycles increments on each edge where F_Stall=1. It holds at all-ones with no wrap.
- Rd==0 never causes a load-use stall.
- A load-use stall does not depend on E_RegWrite. A load always writes.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum hz_state_t {IDLE, MDU_WAIT}
  - constant REG_ZERO
  - the elaboration check MDU_LATENCY>=2
- One natural sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output q), used for StallCycles.

Test Plan:
1. Load-use: E_MemRead=1, E_Rd=5, D_Rs1=5, D_UsesRs1=1 -> F_Stall=D_Stall=E_Flush=1 for one cycle. Same stimulus with E_Rd=0 or D_UsesRs1=0 -> all controls 0.
2. MDU, MDU_LATENCY=4: E_MduStart held high for 4 cycles -> stall+M_Flush in cycles 0,1,2; cycle 3 all 0 with Busy=1; cycle 4 Busy=0. StallCycles=3.
3. MDU_LATENCY=2: E_MduStart for 2 cycles -> stall in cycle 0 only; cycle 1 release. A new E_MduStart in cycle 2 restarts the sequence.
4. Branch priority: E_BranchTaken=1 together with a load-use match and E_MduStart=1 -> D_Flush=E_Flush=1, F_Stall=0, state stays IDLE.
5. Reset mid-wait: rst=1 during cycle 2 of a 32-cycle MDU wait -> outputs 0 during reset, Busy=0 after the edge. StallCycles=0 after the edge, and a new MDU op then starts normally.
6. Saturation with CNT_WIDTH=4: hold an MDU op, MDU_LATENCY=32 -> StallCycles stops at 15.
